// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory stage.
//   state_e   : controller states
//   CNT_W     : width of the wait-state counter (LATENCY up to 15)
//   isBadReq  : accept-time fault check (misaligned, out of range, bad op)
package data_mem_pkg;

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned MAX_ADDR_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // A request is rejected when it is not doubleword aligned, when it
  // addresses beyond the array, or when it is not exactly one of read/write.
  function automatic logic isBadReq(input logic [MAX_ADDR_W-1:0] addr,
                                    input int unsigned            depthLog2,
                                    input logic                   rd,
                                    input logic                   wr);
    logic misaligned;
    logic outOfRange;
    logic badOp;
    misaligned = (addr[2:0] != 3'b000);
    outOfRange = ((addr >> (depthLog2 + 32'd3)) != '0);
    badOp      = (rd == wr);
    return misaligned | outOfRange | badOp;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous doubleword RAM with a registered read port.
//   CLK, Reset_L : clock, async active-low reset (read register only)
//   WrEn, RdEn   : single-cycle access strobes
//   Index        : doubleword index
//   WrData       : store data
//   RdData       : read register; holds the last read value
module dmem_array #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  CLK,
  input  logic                  Reset_L,
  input  logic                  WrEn,
  input  logic                  RdEn,
  input  logic [DEPTH_LOG2-1:0] Index,
  input  logic [DATA_W-1:0]     WrData,
  output logic [DATA_W-1:0]     RdData
);

  localparam int unsigned ENTRIES = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [ENTRIES];

  // Storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (WrEn) begin
      mem[Index] <= WrData;
    end
  end

  // Read register only changes on a read strobe, so writes never disturb it.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      RdData <= '0;
    end else if (RdEn) begin
      RdData <= mem[Index];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory stage controller: accepts LDUR/STUR requests from the ALU
// stage, runs a fixed-latency access to the doubleword array, and reports
// completion and faults.
//   CLK, Reset_L        : clock, async active-low reset
//   Req                 : request strobe, sampled in IDLE only
//   MemRead, MemWrite   : operation select (exactly one must be set)
//   Address             : byte address (ALU BusW)
//   WriteData           : store data
//   ReadData            : last successfully read doubleword
//   Busy                : high while not IDLE; stalls upstream
//   Done                : one-cycle completion pulse
//   Fault               : request rejected; valid with Done
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              Req,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Busy,
  output logic              Done,
  output logic              Fault
);

  if (LATENCY < 1 || LATENCY > 15) begin : gLatencyCheck
    $fatal(1, "data_mem_ctrl: LATENCY must be in 1..15");
  end

  state_e                stateQ;
  state_e                stateD;
  logic [CNT_W-1:0]      cntQ;
  logic [CNT_W-1:0]      cntD;
  logic                  faultD;
  logic                  acceptC;
  logic                  badC;
  logic                  weC;
  logic                  reC;

  logic [DEPTH_LOG2-1:0] idxQ;
  logic [DATA_W-1:0]     wdataQ;
  logic                  isReadQ;
  logic                  isWriteQ;

  // Next-state and access strobes.
  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    faultD  = 1'b0;
    acceptC = 1'b0;
    weC     = 1'b0;
    reC     = 1'b0;
    badC    = isBadReq(MAX_ADDR_W'(Address), DEPTH_LOG2, MemRead, MemWrite);

    unique case (stateQ)
      IDLE: begin
        if (Req) begin
          acceptC = 1'b1;
          if (badC) begin
            stateD = DONE;
            faultD = 1'b1;
          end else begin
            stateD = WAIT;
            cntD   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cntQ != '0) begin
          cntD = cntQ - CNT_W'(1);
        end else begin
          // Array read register lands on this edge, so DONE sees fresh data.
          weC    = isWriteQ;
          reC    = isReadQ;
          stateD = DONE;
        end
      end
      DONE: begin
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // State, counter and registered status outputs.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      stateQ <= IDLE;
      cntQ   <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Fault  <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      Busy   <= (stateD != IDLE);
      Done   <= (stateD == DONE);
      Fault  <= faultD;
    end
  end

  // Request capture; inputs are ignored between accepts.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      idxQ     <= '0;
      wdataQ   <= '0;
      isReadQ  <= 1'b0;
      isWriteQ <= 1'b0;
    end else if (acceptC) begin
      idxQ     <= Address[DEPTH_LOG2+2:3];
      wdataQ   <= WriteData;
      isReadQ  <= MemRead;
      isWriteQ <= MemWrite;
    end
  end

  dmem_array #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) uArray (
    .CLK    (CLK),
    .Reset_L(Reset_L),
    .WrEn   (weC),
    .RdEn   (reC),
    .Index  (idxQ),
    .WrData (wdataQ),
    .RdData (ReadData)
  );

endmodule
